// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART TX state encoding, frame constants and baud divisor helper.
// Frame length depends on UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int FRAME_BITS = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

  function automatic int baud_divisor(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with count register resolving full/empty.
// Read data is the combinational head entry; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count_q <= count_q + CW'(1);
      else if (!do_push && do_pop)
        count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter, LSB first, registered tx.
// Defining UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_uart,
  input  logic [7:0]                         data,
  output logic                               tx,
  output logic                               ready,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int BAUD_DIVISOR = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BCW = $clog2(BAUD_DIVISOR + 1);

  uart_state_t    state;
  uart_state_t    state_next;
  logic [BCW-1:0] baud_cnt;
  logic [BCW-1:0] baud_next;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_next;
  logic [7:0]     shifter;
  logic [7:0]     shifter_next;
  logic           tx_q;
  logic           tx_next;
  logic           baud_last;

  logic           fifo_pop;
  logic [7:0]     fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_cnt;

`ifdef UART_TX_PARITY_EN
  logic           parity_q;
  logic           parity_next;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (start_uart),
    .wr_data (data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign baud_last  = (baud_cnt == BCW'(BAUD_DIVISOR - 1));
  assign tx         = tx_q;
  assign ready      = !fifo_full;
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign fifo_count = fifo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shifter  <= shifter_next;
      tx_q     <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt + BCW'(1);
    bit_next     = bit_idx;
    shifter_next = shifter;
    fifo_pop     = 1'b0;
    tx_next      = 1'b1;

    case (state)
      ST_IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shifter_next = fifo_head;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_next    = '0;
          shifter_next = shifter >> 1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          baud_next = '0;
          // Chain straight into the next start bit so bursts have no idle gap.
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            shifter_next = fifo_head;
            state_next   = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        baud_next  = '0;
        state_next = ST_IDLE;
      end
    endcase

`ifdef UART_TX_PARITY_EN
    // Parity is latched at load time because the shifter is consumed during DATA.
    parity_next = fifo_pop ? ^fifo_head : parity_q;
`endif

    // tx is registered, so it is driven from the state being entered.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shifter_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a frame-schedule reference model.
// Honours UART_TX_PARITY_EN for the expected frame length.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 80_000_000;
  localparam int BAUD   = 10_000_000;
  localparam int DIV    = 8;
  localparam int DEPTH  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_uart = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       ready;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_fifo #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_uart (start_uart),
    .data       (data),
    .tx         (tx),
    .ready      (ready),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int         vec = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_pop = -1000000;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] mq[$];
  int         peak = 0;

  // Expected line level after edge e, from the most recent frame start.
  function automatic logic exp_tx(input int e);
    int off;
    int slot;
    off = e - last_pop;
    if (off < 0 || off >= FRAME) return 1'b1;
    slot = off / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return last_byte[slot-1];
    if (NBITS == 11 && slot == 9) return ^last_byte;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int   e;
    logic active;
    e = cyc - 1;
    active = (e - last_pop >= 0) && (e - last_pop < FRAME);
    chk("tx", {7'd0, tx}, {7'd0, exp_tx(e)});
    chk("fifo_count", {3'd0, fifo_count}, 8'(mq.size()));
    chk("ready", {7'd0, ready}, {7'd0, mq.size() != DEPTH});
    chk("busy", {7'd0, busy}, {7'd0, active || mq.size() != 0});
  endtask

  // One clock edge: predict pop/push from pre-edge model state, then compare.
  task automatic tick();
    logic do_pop;
    logic do_push;
    do_pop  = (mq.size() != 0) && (cyc >= last_pop + FRAME);
    do_push = start_uart && (mq.size() < DEPTH);
    @(posedge clk);
    if (do_pop) begin
      last_byte = mq.pop_front();
      last_pop  = cyc;
    end
    if (do_push) mq.push_back(data);
    cyc++;
    #1;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    check_outputs();
  endtask

  task automatic model_clear();
    mq.delete();
    last_pop = -1000000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_uart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    start_uart = 1'b1;
    data = b;
    tick();
    start_uart = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((mq.size() != 0 || (cyc - 1 - last_pop) < FRAME) && n < limit) begin
      tick();
      n++;
    end
    vec++;
    assert (n < limit) else begin
      bad++;
      $error("FAIL drain_timeout cyc=%0d observed=%0d expected<%0d", cyc, n, limit);
    end
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int n;

    // Single byte and its exact frame timing.
    do_reset();
    tick();
    write_byte(8'hA5);
    chk("latency_pre", {7'd0, tx}, 8'd1);
    tick();
    chk("latency_low", {7'd0, tx}, 8'd0);
    drain(3 * FRAME);
`ifdef UART_TX_PARITY_EN
    write_byte(8'h07);
    drain(3 * FRAME);
`endif

    // Back-to-back burst with zero idle gap.
    peak = 0;
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h55);
    drain(5 * FRAME);
    chk("peak_count", 8'(peak), 8'd2);

    // Fill from reset, then overfill; extra writes must be dropped.
    do_reset();
    for (int i = 1; i <= 20; i++) write_byte(8'(i));
    chk("full_ready", {7'd0, ready}, 8'd0);
    chk("full_count", {3'd0, fifo_count}, 8'd16);
    drain(20 * FRAME);

    // Simultaneous push and pop on the stop-final edge.
    do_reset();
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    n = 0;
    while (cyc != last_pop + FRAME && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("simul_reach", {7'd0, cyc == last_pop + FRAME}, 8'd1);
    write_byte(8'($urandom));
    chk("simul_count", {3'd0, fifo_count}, 8'd1);
    drain(4 * FRAME);

    // Reset asserted during data bit 3 with a byte still queued.
    do_reset();
    write_byte(8'h00);
    write_byte(8'h3C);
    n = 0;
    while ((cyc - 1 - last_pop) != 4 * DIV + 3 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("pre_reset_tx", {7'd0, tx}, 8'd0);
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("async_tx", {7'd0, tx}, 8'd1);
    chk("async_count", {3'd0, fifo_count}, 8'd0);
    chk("async_ready", {7'd0, ready}, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * FRAME) tick();

    // Random dense traffic, exercising full-FIFO drops.
    for (int i = 0; i < 800; i++) begin
      start_uart = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      tick();
    end
    start_uart = 1'b0;
    drain(20 * FRAME);

    // Random sparse traffic, exercising idle restarts.
    for (int i = 0; i < 800; i++) begin
      start_uart = ($urandom_range(0, 99) < 2);
      data = 8'($urandom);
      tick();
    end
    start_uart = 1'b0;
    drain(20 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- FIFO-buffered UART transmitter that sits downstream of the SPI-to-UART bridge state machine.
- Accepts bytes through a one-cycle strobe/ready handshake, queues them, and serialises them 8N1, LSB first, on the UART TX pin.
- `ready` means "FIFO can accept a byte". It does not mean "line idle", so upstream can burst several bytes without waiting a full frame per byte.

Parameters:
- CLOCK_FREQUENCY, 27000000, system clock in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- FIFO_DEPTH, 16, number of queued bytes; must be a power of 2 and at least 2.
- BAUD_DIVISOR, CLOCK_FREQUENCY/BAUD_RATE (integer division, 234 at defaults), clocks per bit. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_uart  in  1  enqueue strobe; one byte per high cycle.
- data  in  8  byte to enqueue, sampled when start_uart && ready.
- tx  out  1  serial output, idle high; registered.
- ready  out  1  FIFO not full.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the byte in the shifter.

Behaviour:
- Reset (async assert, synchronous release by design):
  - tx=1, ready=1, busy=0, fifo_count=0.
  - FIFO pointers cleared, FSM in IDLE, baud counter=0, bit index=0.
  - Asserting reset mid-frame returns tx high immediately and discards the frame and all queued data.
- Handshake:
  - A write is accepted on the rising edge where start_uart=1 and ready=1.
  - start_uart while ready=0 is dropped silently; FIFO contents are unchanged.
  - ready = (fifo_count != FIFO_DEPTH), decoded from registered state only.
  - A pop in the same cycle does NOT make a full FIFO writable in that cycle.
- Simultaneous write and pop: fifo_count is unchanged and both operations take effect.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty are resolved by the count register.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shifter, clear the baud counter, and go to START.
  - START: tx=0 for BAUD_DIVISOR clocks, then go to DATA with bit index=0.
  - DATA: tx=shifter[0] for BAUD_DIVISOR clocks, then shift right. After bit index 7, go to STOP.
  - STOP: tx=1 for BAUD_DIVISOR clocks. On the final clock, if the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Timing:
  - Baud counter counts 0..BAUD_DIVISOR-1; the bit advances when the counter equals BAUD_DIVISOR-1.
  - Latency: a write accepted at edge k into an empty FIFO with FSM in IDLE causes tx to go low after edge k+1.
  - Frame length is exactly 10*BAUD_DIVISOR clocks.
- busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for BAUD_DIVISOR clocks.
  - Frame is 11*BAUD_DIVISOR clocks.
- When undefined: no PARITY state or parity logic exists, and the frame is 10 bits.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP) as localparams/typedef.
  - The BAUD_DIVISOR derivation function.
  - Frame-bit constants.
- One sub-module: sync_fifo (parameterised width/depth). It has push/pop/full/empty/count ports and the same async active-low reset.
- The FSM, baud counter and shifter remain in uart_tx_fifo.

Test Plan:
All scenarios use BAUD_RATE=CLOCK_FREQUENCY/8 (BAUD_DIVISOR=8).
- Single byte: after reset, write 0xA5 once.
  - tx low one cycle after acceptance for 8 clocks.
  - Then bits 1,0,1,0,0,1,0,1, 8 clocks each; then stop high 8 clocks.
  - busy drops after 80 clocks.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Three frames totalling 240 clocks with no idle gap between stop and next start.
  - fifo_count peaks at 2.
- Full FIFO: write 17 bytes 0x01..0x11 on consecutive cycles from reset.
  - ready falls once FIFO holds 16.
  - Every write with ready=0 is dropped.
  - Exactly 17 bytes are transmitted (first byte leaves the FIFO before fill completes); bytes arrive in order.
- Simultaneous push/pop: with FIFO holding 1 byte, write at the STOP-final edge.
  - fifo_count stays 1.
  - Data order is preserved.
- Reset mid-frame: assert rst_n=0 during DATA bit 3.
  - tx=1 asynchronously, fifo_count=0, ready=1.
  - After release, tx stays high with no residual frame.
- Parity (UART_TX_PARITY_EN defined): write 0x07.
  - Parity bit=1.
  - Frame 88 clocks; the stop bit follows parity.
